// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//
// Purpose:
//   Multicycle sequencer between the processor control unit and a synchronous,
//   word-addressed data memory. Takes one load or store at a time (byte,
//   halfword or word). Sub-word stores use read-modify-write. Sub-word loads are
//   extracted and sign- or zero-extended to 32 bits. Misaligned requests
//   complete immediately with misaligned=1 and do not access memory.
//
// Parameters:
//   MEM_LATENCY  cycles from mem_addr driven (read) to mem_rdata valid, 1..7
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   req         request strobe, sampled only while idle (busy=0)
//   req_store   1=store, 0=load
//   req_size    01=byte, 10=halfword, 11=word, 00=illegal
//   req_signed  loads only: 1=sign-extend, 0=zero-extend
//   req_addr    byte address
//   req_wdata   store data, low-order bits used for sub-word stores
//   busy        high from the cycle after acceptance through the done cycle
//   done        one-cycle completion pulse
//   rdata       load result, held until the next load completes
//   misaligned  valid with done, 1=request rejected
//   mem_addr    word address to memory (registered)
//   mem_wr      memory write enable, high only in the write cycle
//   mem_wdata   memory write data (registered)
//   mem_rdata   memory read data
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // WAIT is held for MEM_LATENCY cycles; the counter is loaded with
  // MEM_LATENCY-1 and the read data is captured when it reaches zero.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        isStore_q, isStore_d;
  logic [1:0]  size_q, size_d;
  logic        isSigned_q, isSigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [2:0]  waitCnt_q, waitCnt_d;

  logic        reqMisaligned;

  // Pick the addressed byte or halfword out of a little-endian memory word and
  // widen it to 32 bits; words pass through untouched.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
      SIZE_HALF: r = {{16{sgn & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/halfword of the old memory word with the
  // low-order store data, preserving every other byte.
  function automatic logic [31:0] mergeStore(
    input logic [31:0] oldWord,
    input logic [31:0] newData,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = oldWord;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = newData[7:0];
        2'd1:    r[15:8]  = newData[7:0];
        2'd2:    r[23:16] = newData[7:0];
        default: r[31:24] = newData[7:0];
      endcase
    end else if (size == SIZE_HALF) begin
      if (lane[1]) begin
        r[31:16] = newData[15:0];
      end else begin
        r[15:0] = newData[15:0];
      end
    end else begin
      r = newData;
    end
    return r;
  endfunction

  // Alignment check on the raw request: illegal size, odd halfword address,
  // or word address that is not a multiple of four.
  always_comb begin
    reqMisaligned = 1'b0;
    case (req_size)
      SIZE_HALF: reqMisaligned = req_addr[0];
      SIZE_WORD: reqMisaligned = (req_addr[1:0] != 2'b00);
      SIZE_BYTE: reqMisaligned = 1'b0;
      default:   reqMisaligned = 1'b1;
    endcase
  end

  // State and datapath registers. Reset abandons any access in flight,
  // including an old word captured for read-modify-write, so no partial write
  // can follow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      isStore_q    <= 1'b0;
      size_q       <= 2'b00;
      isSigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
      memAddr_q    <= 32'h0;
      memWdata_q   <= 32'h0;
      waitCnt_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      isStore_q    <= isStore_d;
      size_q       <= size_d;
      isSigned_q   <= isSigned_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; anything arriving
  // while busy is dropped. Word stores go straight to WRITE, everything else
  // that touches memory reads first, and the capture at the end of WAIT either
  // finishes a load or builds the merged word for a sub-word store.
  always_comb begin
    state_d      = state_q;
    isStore_d    = isStore_q;
    size_d       = size_q;
    isSigned_d   = isSigned_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    waitCnt_d    = waitCnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          isStore_d  = req_store;
          size_d     = req_size;
          isSigned_d = req_signed;
          lane_d     = req_addr[1:0];
          wdata_d    = req_wdata;
          if (reqMisaligned) begin
            misaligned_d = 1'b1;
            state_d      = DONE;
          end else begin
            misaligned_d = 1'b0;
            memAddr_d    = {req_addr[31:2], 2'b00};
            if (req_store && (req_size == SIZE_WORD)) begin
              memWdata_d = req_wdata;
              state_d    = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end

      READ: begin
        waitCnt_d = WAIT_LOAD;
        state_d   = WAIT;
      end

      WAIT: begin
        if (waitCnt_q == 3'd0) begin
          if (isStore_q) begin
            memWdata_d = mergeStore(mem_rdata, wdata_q, size_q, lane_q);
            state_d    = WRITE;
          end else begin
            rdata_d = extractLoad(mem_rdata, size_q, lane_q, isSigned_q);
            state_d = DONE;
          end
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end

      WRITE: begin
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and memory-port outputs come straight from registers so the memory
  // sees glitch-free, stable address and data.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_wr     = (state_q == WRITE);
  assign rdata      = rdata_q;
  assign misaligned = misaligned_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;

endmodule
